// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with grant hold and forced release after MAX_HOLD cycles.
// Optional protocol assertions: define RR_HOLD_ARBITER_SVA_EN.
module rr_hold_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 timeout
);
  localparam int IDW = $clog2(N);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic             found_s;
  logic [IDW-1:0]   win_s;
  logic             owner_req_s;
  logic             at_max_s;

  assign owner_req_s = req[gnt_id_q];
  assign at_max_s    = (hold_cnt_q == CNT_W'(MAX_HOLD));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state logic, including the rotating-priority scan from ptr
  always_comb begin
    found_s    = 1'b0;
    win_s      = '0;
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % N;
      if (!found_s && req[idx]) begin
        found_s = 1'b1;
        win_s   = IDW'(idx);
      end
    end
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d    = GRANT;
          hold_cnt_d = CNT_W'(1);
          ptr_d      = (win_s == IDW'(N - 1)) ? '0 : win_s + IDW'(1);
        end else begin
          state_d    = IDLE;
        end
      end
      GRANT: begin
        // Both normal and forced release go through IDLE for one cycle
        if (!owner_req_s || at_max_s) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    gnt_d     = '0;
    gnt_id_d  = '0;
    busy_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          gnt_d    = N'(1) << win_s;
          gnt_id_d = win_s;
          busy_d   = 1'b1;
        end else begin
          busy_d   = 1'b0;
        end
      end
      GRANT: begin
        if (!owner_req_s) begin
          timeout_d = 1'b0;
        end else if (at_max_s) begin
          timeout_d = 1'b1;
        end else begin
          gnt_d    = gnt_q;
          gnt_id_d = gnt_id_q;
          busy_d   = 1'b1;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

`ifdef RR_HOLD_ARBITER_SVA_EN
  rr_hold_arbiter_sva #(.N(N), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) u_sva (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt_q),
    .gnt_id   (gnt_id_q),
    .busy     (busy_q),
    .timeout  (timeout_q),
    .hold_cnt (hold_cnt_q)
  );
`else
`endif

endmodule

`ifdef RR_HOLD_ARBITER_SVA_EN
// Protocol checker bound into the arbiter when assertions are enabled.
module rr_hold_arbiter_sva #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input logic                 clk,
  input logic                 rst,
  input logic [N-1:0]         req,
  input logic [N-1:0]         gnt,
  input logic [$clog2(N)-1:0] gnt_id,
  input logic                 busy,
  input logic                 timeout,
  input logic [CNT_W-1:0]     hold_cnt
);
  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_gap: assert property (@(posedge clk) disable iff (rst) $fell(busy) |-> !busy);
  a_force: assert property (@(posedge clk) disable iff (rst)
    (busy && hold_cnt == CNT_W'(MAX_HOLD) && req[gnt_id]) |=> (timeout && !busy));
  a_pulse: assert property (@(posedge clk) disable iff (rst) timeout |=> !timeout);
  a_serve: assert property (@(posedge clk) disable iff (rst) (!busy && |req) |=> busy);

  for (genvar i = 0; i < N; i++) begin : g_rel
    a_release: assert property (@(posedge clk) disable iff (rst)
      (gnt[i] && !req[i]) |=> !gnt[i]);
  end
endmodule
`else
`endif
